// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetch: raster position -> sprite ROM address -> palette index with opaque flag.
// Latency: 3 Clk from DrawX/DrawY/syncs to pix_index/pix_valid/hs_out/vs_out/display_en_out.
// Backpressure: none; one pixel is accepted every Clk unconditionally.
//
// Ports:
//   Clk, Reset            pixel clock, synchronous active-high reset
//   DrawX, DrawY          current raster column / row
//   display_en_in, hs_in, vs_in   raster timing (syncs active-low)
//   sprite_x, sprite_y, flip_x    requested sprite placement, latched at vsync assertion
//   rom_addr / rom_q      sprite ROM read port (data returns 1 Clk after address)
//   pix_index, pix_valid  palette index and opaque-visible flag
//   display_en_out, hs_out, vs_out  timing delayed to match pix_index
module sprite_pixel_fetch #(
    parameter int          SPR_W       = 32,
    parameter int          SPR_H       = 32,
    parameter int          SCALE_LOG2  = 1,
    parameter logic [3:0]  TRANSPARENT = 4'h0,
    parameter int          ADDR_W      = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              display_en_in,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              flip_x,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_q,
    output logic [3:0]        pix_index,
    output logic              pix_valid,
    output logic              display_en_out,
    output logic              hs_out,
    output logic              vs_out
);

    // On-screen extent of the magnified sprite.
    localparam int SW = SPR_W << SCALE_LOG2;
    localparam int SH = SPR_H << SCALE_LOG2;

    // Frame latch state
    logic              vs_prev_q;
    logic [9:0]        shadow_x_q, shadow_x_d;
    logic [9:0]        shadow_y_q, shadow_y_d;
    logic              flip_q,     flip_d;
    logic              vs_fall;

    // Stage 1
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              in_box_d1_q, in_box;
    logic              de_d1_q, hs_d1_q, vs_d1_q;

    // Stage 2
    logic              in_box_d2_q;
    logic              de_d2_q, hs_d2_q, vs_d2_q;

    // Stage 3
    logic [3:0]        pix_index_q, pix_index_d;
    logic              pix_valid_q, pix_valid_d;
    logic              de_d3_q, hs_d3_q, vs_d3_q;

    // Stage-1 arithmetic, all 11 bits wide so a sprite hanging past column/row
    // 1023 compares correctly instead of wrapping its right/bottom bound.
    logic [10:0] draw_x_e, draw_y_e, sx_e, sy_e, x_end, y_end;
    logic [10:0] dx, dy, tx, ty, tx_f;
    logic [31:0] addr_full;

    always_comb begin
        vs_fall    = vs_prev_q & ~vs_in;
        shadow_x_d = shadow_x_q;
        shadow_y_d = shadow_y_q;
        flip_d     = flip_q;
        // Placement only changes at vsync assertion so a sprite never tears.
        if (vs_fall) begin
            shadow_x_d = sprite_x;
            shadow_y_d = sprite_y;
            flip_d     = flip_x;
        end
    end

    always_comb begin
        draw_x_e  = {1'b0, DrawX};
        draw_y_e  = {1'b0, DrawY};
        sx_e      = {1'b0, shadow_x_q};
        sy_e      = {1'b0, shadow_y_q};
        x_end     = sx_e + 11'(SW);
        y_end     = sy_e + 11'(SH);
        dx        = draw_x_e - sx_e;
        dy        = draw_y_e - sy_e;
        in_box    = (draw_x_e >= sx_e) && (draw_x_e < x_end) &&
                    (draw_y_e >= sy_e) && (draw_y_e < y_end);
        tx        = dx >> SCALE_LOG2;
        ty        = dy >> SCALE_LOG2;
        tx_f      = flip_q ? (11'(SPR_W - 1) - tx) : tx;
        addr_full = 32'(ty) * 32'(SPR_W) + 32'(tx_f);
        // Outside the box the address is a don't-care; holding it avoids needless ROM toggling.
        rom_addr_d = in_box ? addr_full[ADDR_W-1:0] : rom_addr_q;
    end

    always_comb begin
        pix_index_d = in_box_d2_q ? rom_q : 4'h0;
        pix_valid_d = in_box_d2_q && de_d2_q && (rom_q != TRANSPARENT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_prev_q   <= 1'b1;
            shadow_x_q  <= '0;
            shadow_y_q  <= '0;
            flip_q      <= 1'b0;
            rom_addr_q  <= '0;
            in_box_d1_q <= 1'b0;
            de_d1_q     <= 1'b0;
            hs_d1_q     <= 1'b1;
            vs_d1_q     <= 1'b1;
            in_box_d2_q <= 1'b0;
            de_d2_q     <= 1'b0;
            hs_d2_q     <= 1'b1;
            vs_d2_q     <= 1'b1;
            pix_index_q <= 4'h0;
            pix_valid_q <= 1'b0;
            de_d3_q     <= 1'b0;
            hs_d3_q     <= 1'b1;
            vs_d3_q     <= 1'b1;
        end else begin
            vs_prev_q   <= vs_in;
            shadow_x_q  <= shadow_x_d;
            shadow_y_q  <= shadow_y_d;
            flip_q      <= flip_d;
            rom_addr_q  <= rom_addr_d;
            in_box_d1_q <= in_box;
            de_d1_q     <= display_en_in;
            hs_d1_q     <= hs_in;
            vs_d1_q     <= vs_in;
            in_box_d2_q <= in_box_d1_q;
            de_d2_q     <= de_d1_q;
            hs_d2_q     <= hs_d1_q;
            vs_d2_q     <= vs_d1_q;
            pix_index_q <= pix_index_d;
            pix_valid_q <= pix_valid_d;
            de_d3_q     <= de_d2_q;
            hs_d3_q     <= hs_d2_q;
            vs_d3_q     <= vs_d2_q;
        end
    end

    assign rom_addr       = rom_addr_q;
    assign pix_index      = pix_index_q;
    assign pix_valid      = pix_valid_q;
    assign display_en_out = de_d3_q;
    assign hs_out         = hs_d3_q;
    assign vs_out         = vs_d3_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch with a behavioural 1-cycle sprite ROM.
// Latency: checks the 3-cycle index/sync alignment and the 1-cycle address stage.
// Backpressure: none exercised; the DUT accepts a pixel every cycle.
module tb_sprite_pixel_fetch;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [9:0] DrawX, DrawY;
    logic       display_en_in, hs_in, vs_in;
    logic [9:0] sprite_x, sprite_y;
    logic       flip_x;
    logic [9:0] rom_addr;
    logic [3:0] rom_q;
    logic [3:0] pix_index;
    logic       pix_valid, display_en_out, hs_out, vs_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] hist_de, hist_hs, hist_vs;
    logic       chk_sync = 1'b0;

    sprite_pixel_fetch dut (
        .Clk(Clk), .Reset(Reset),
        .DrawX(DrawX), .DrawY(DrawY),
        .display_en_in(display_en_in), .hs_in(hs_in), .vs_in(vs_in),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .flip_x(flip_x),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .pix_index(pix_index), .pix_valid(pix_valid),
        .display_en_out(display_en_out), .hs_out(hs_out), .vs_out(vs_out)
    );

    always #5 Clk = ~Clk;

    // ROM contents: address 5 is transparent, otherwise low nibble + 1 (so address 6 -> 7).
    function automatic logic [3:0] rom_f(input logic [9:0] a);
        if (a == 10'd5) return 4'h0;
        return a[3:0] + 4'h1;
    endfunction

    always @(posedge Clk) rom_q <= rom_f(rom_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One pixel clock; outputs are sampled 1 time unit after the edge.
    task automatic tick;
        @(posedge Clk);
        #1;
        hist_de = {hist_de[1:0], display_en_in};
        hist_hs = {hist_hs[1:0], hs_in};
        hist_vs = {hist_vs[1:0], vs_in};
        if (chk_sync) begin
            chk("de_dly3", display_en_out, hist_de[2]);
            chk("hs_dly3", hs_out, hist_hs[2]);
            chk("vs_dly3", vs_out, hist_vs[2]);
            chk("pv_when_de0", pix_valid & ~display_en_out, 0);
        end
    endtask

    task automatic pix(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        tick();
    endtask

    // Produce one vsync assertion edge carrying the requested placement.
    task automatic latch(input int x, input int y, input logic f);
        sprite_x = 10'(x);
        sprite_y = 10'(y);
        flip_x   = f;
        vs_in    = 1'b0;
        tick();
        vs_in    = 1'b1;
        tick();
    endtask

    initial begin
        Reset = 1'b1;
        DrawX = '0; DrawY = '0;
        display_en_in = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
        sprite_x = '0; sprite_y = '0; flip_x = 1'b0;
        hist_de = '0; hist_hs = '1; hist_vs = '1;
        tick();
        tick();
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_pix_index", pix_index, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_de_out", display_en_out, 0);
        chk("rst_hs_out", hs_out, 1);
        chk("rst_vs_out", vs_out, 1);
        Reset = 1'b0;
        hist_de = '0; hist_hs = '1; hist_vs = '1;

        // 1: raster slice spanning the bottom of the active area and vsync.
        sprite_x = 10'd100; sprite_y = 10'd470; flip_x = 1'b0;
        chk_sync = 1'b1;
        for (int y = 478; y < 494; y++) begin
            for (int x = 0; x < 800; x++) begin
                display_en_in = (x < 640) && (y < 480);
                hs_in         = !((x >= 656) && (x < 752));
                vs_in         = !((y >= 490) && (y < 492));
                pix(x, y);
            end
        end
        chk_sync = 1'b0;
        display_en_in = 1'b1; hs_in = 1'b1; vs_in = 1'b1;

        // 2: addressing with 2x magnification.
        latch(100, 50, 1'b0);
        pix(100, 50);  chk("addr_100_50", rom_addr, 0);
        pix(101, 50);  chk("addr_101_50", rom_addr, 0);
        pix(102, 50);  chk("addr_102_50", rom_addr, 1);
        pix(163, 113); chk("addr_163_113", rom_addr, 1023);
        pix(164, 113); chk("addr_hold_164", rom_addr, 1023);

        // 3: transparency and display-enable gating.
        pix(110, 50);
        pix(112, 50);
        pix(0, 0);     chk("transp_idx", pix_index, 0);
                       chk("transp_vld", pix_valid, 0);
        pix(0, 0);     chk("opaque_idx", pix_index, 7);
                       chk("opaque_vld", pix_valid, 1);
        display_en_in = 1'b0;
        pix(112, 50);
        display_en_in = 1'b1;
        pix(0, 0);
        pix(0, 0);     chk("blank_idx", pix_index, 7);
                       chk("blank_vld", pix_valid, 0);

        // 4: horizontal flip.
        latch(0, 0, 1'b1);
        pix(0, 0);     chk("flip_addr_0", rom_addr, 31);
        pix(2, 0);     chk("flip_addr_2", rom_addr, 30);

        // 5: tear-free latch.
        latch(100, 50, 1'b0);
        sprite_x = 10'd200;
        pix(150, 50);  chk("tear_old_pos", rom_addr, 25);
        vs_in = 1'b0;
        pix(150, 50);  chk("tear_edge_cyc", rom_addr, 25);
        vs_in = 1'b1;
        pix(210, 50);  chk("tear_new_pos", rom_addr, 5);
        sprite_x = 10'd300;
        vs_in = 1'b0;
        pix(0, 0);
        vs_in = 1'b1;
        pix(302, 50);  chk("same_cyc_latch", rom_addr, 1);

        // 6: right-edge clip past column 1023, then a mid-line reset.
        latch(1000, 50, 1'b0);
        pix(1010, 51); chk("clip_addr_1010", rom_addr, 5);
        pix(1012, 51); chk("clip_addr_1012", rom_addr, 6);
        pix(1023, 50); chk("clip_addr_1023", rom_addr, 11);
        hs_in = 1'b0;
        pix(0, 0);     chk("clip_idx", pix_index, 7);
                       chk("clip_vld", pix_valid, 1);
        pix(0, 0);
        pix(0, 0);     chk("pre_rst_hs", hs_out, 0);
        Reset = 1'b1;
        pix(1012, 51);
        chk("midrst_rom_addr", rom_addr, 0);
        chk("midrst_pix_index", pix_index, 0);
        chk("midrst_pix_valid", pix_valid, 0);
        chk("midrst_de_out", display_en_out, 0);
        chk("midrst_hs_out", hs_out, 1);
        chk("midrst_vs_out", vs_out, 1);
        Reset = 1'b0;
        pix(2, 0);     chk("post_rst_shadow", rom_addr, 1);
                       chk("post_rst_hs_1", hs_out, 1);
                       chk("post_rst_vld_1", pix_valid, 0);
        pix(2, 0);     chk("post_rst_hs_2", hs_out, 1);
        pix(2, 0);     chk("post_rst_hs_3", hs_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
